// File: rtl/hamming_serial_tx.sv
// Serial transmitter for 7-bit Hamming codewords.
// Codewords are queued in a small FIFO through a register interface and sent
// as frames of one start bit (0), seven data bits LSB first and one stop bit (1).
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | line high, waiting for enable and a queued codeword
// S_START | start bit (0) for DIV+1 cycles
// S_DATA  | seven data bits, LSB first, DIV+1 cycles each
// S_STOP  | stop bit (1) for DIV+1 cycles, then back to idle
module hamming_serial_tx #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] DIV_RESET  = 8'h0F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state;
   state_t           next_state;

   logic [6:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [3:0]       count;

   logic [7:0]       div_q;
   logic             enable_q;
   logic             overflow_q;

   logic [7:0]       baud_cnt;
   logic [2:0]       bit_idx;
   logic [6:0]       shreg;
   logic             tx_q;
   logic             tx_d;
   logic             busy;

   logic             baud_zero;
   logic             fifo_empty;
   logic             fifo_full;
   logic             wr_txdata;
   logic             wr_div;
   logic             wr_status;
   logic             wr_ctrl;
   logic             pop;
   logic             push_ok;
   logic             push_drop;
   logic             unused_ui;

   assign unused_ui  = ^ui_in;

   assign baud_zero  = (baud_cnt == 8'd0);
   assign fifo_empty = (count == 4'd0);
   assign fifo_full  = (count == 4'(FIFO_DEPTH));

   assign wr_txdata  = data_write && (address == 4'h0);
   assign wr_div     = data_write && (address == 4'h1);
   assign wr_status  = data_write && (address == 4'h2);
   assign wr_ctrl    = data_write && (address == 4'h3);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // still accepted when the transmitter is taking the head entry.
   assign pop        = (state == S_IDLE) && enable_q && !fifo_empty;
   assign push_ok    = wr_txdata && (!fifo_full || pop);
   assign push_drop  = wr_txdata && !push_ok;

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 4'd0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while empty, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= data_in[6:0];
   end

   // Configuration registers; an overflow in the same cycle beats a clear
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= DIV_RESET;
         enable_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_div)  div_q    <= data_in;
         if (wr_ctrl) enable_q <= data_in[0];
         if (push_drop)
            overflow_q <= 1'b1;
         else if (wr_status && data_in[3])
            overflow_q <= 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (pop) next_state = S_START;
         S_START: if (baud_zero) next_state = S_DATA;
         S_DATA:  if (baud_zero && (bit_idx == 3'd6)) next_state = S_STOP;
         S_STOP:  if (baud_zero) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // FSM outputs: busy and the value the tx register takes at the next edge
   always_comb begin
      busy = (state != S_IDLE);
      tx_d = 1'b1;
      case (next_state)
         S_START: tx_d = 1'b0;
         S_DATA: begin
            if (state == S_START) tx_d = shreg[0];
            else if (baud_zero)   tx_d = shreg[1];
            else                  tx_d = shreg[0];
         end
         default: tx_d = 1'b1;
      endcase
   end

   // Bit-timing datapath: baud down-counter, shift register, bit index, tx flop
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q     <= 1'b1;
         shreg    <= 7'd0;
         bit_idx  <= 3'd0;
         baud_cnt <= 8'd0;
      end else begin
         tx_q <= tx_d;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  shreg    <= fifo_mem[rd_ptr];
                  bit_idx  <= 3'd0;
                  baud_cnt <= div_q;
               end
            end
            S_START: begin
               if (baud_zero) baud_cnt <= div_q;
               else           baud_cnt <= baud_cnt - 8'd1;
            end
            S_DATA: begin
               if (baud_zero) begin
                  baud_cnt <= div_q;
                  shreg    <= shreg >> 1;
                  bit_idx  <= bit_idx + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt - 8'd1;
               end
            end
            S_STOP: begin
               if (!baud_zero) baud_cnt <= baud_cnt - 8'd1;
            end
            default: baud_cnt <= baud_cnt;
         endcase
      end
   end

   // Register read mux
   always_comb begin
      data_out = 8'h00;
      case (address)
         4'h0:    data_out = {5'b0, count[2:0]};
         4'h1:    data_out = div_q;
         4'h2:    data_out = {4'b0, overflow_q, busy, fifo_full, fifo_empty};
         4'h3:    data_out = {7'b0, enable_q};
         default: data_out = 8'h00;
      endcase
   end

   assign uo_out = {6'b0, busy, tx_q};

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx: register-map vector table followed by
// hand-written frame sequences checked cycle by cycle against a bit-timing model.
module tb_hamming_serial_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [3:0] address = 4'h0;
   logic       data_write = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;

   int checks   = 0;
   int failures = 0;

   hamming_serial_tx dut (
      .clk        (clk),
      .rst        (rst),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] addr;
      logic       wr;
      logic [7:0] wdata;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   // one clock edge; strobes last exactly one cycle, ui_in is noise
   task automatic tick();
      @(posedge clk);
      #1;
      data_write = 1'b0;
      ui_in = 8'($urandom);
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      tick();
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
      address = a;
      #1;
      check(name, data_out, exp);
   endtask

   function automatic logic exp_bit(input logic [6:0] cw, input int i, input int first_len,
                                    input int rest_len);
      int b;
      if (i < first_len) b = 0;
      else               b = 1 + (i - first_len) / rest_len;
      if (b == 0)      return 1'b0;
      else if (b <= 7) return cw[b-1];
      else             return 1'b1;
   endfunction

   // Called one edge before the pop; checks every cycle of the frame.
   task automatic expect_frame(input logic [6:0] cw, input int first_len, input int rest_len,
                               input bit div_wr, input logic [7:0] new_div);
      int total;
      total = first_len + 8 * rest_len;
      for (int i = 0; i < total; i++) begin
         if (div_wr && i == 1) begin
            address    = 4'h1;
            data_in    = new_div;
            data_write = 1'b1;
         end
         tick();
         check($sformatf("frame_%02h_tx[%0d]", cw, i), {7'b0, uo_out[0]},
               {7'b0, exp_bit(cw, i, first_len, rest_len)});
         check($sformatf("frame_%02h_busy[%0d]", cw, i), {7'b0, uo_out[1]}, 8'h01);
      end
   endtask

   // Receiver for DIV=0 frames: current sample or a later one must be the start bit.
   task automatic rx_frame(output logic [6:0] cw);
      int n;
      n  = 0;
      cw = 7'd0;
      while (!(uo_out[1] && !uo_out[0]) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         bound_fail("rx_start");
      end else begin
         for (int j = 0; j < 7; j++) begin
            tick();
            cw[j] = uo_out[0];
         end
         tick();
         check("rx_stop", uo_out, 8'h03);
      end
   endtask

   initial begin
      logic [6:0] got;
      logic [6:0] exp_cw;
      int n;

      vecs[0]  = '{4'h0, 1'b0, 8'h00, 8'h00, "txdata_rst"};
      vecs[1]  = '{4'h1, 1'b0, 8'h00, 8'h0F, "div_rst"};
      vecs[2]  = '{4'h2, 1'b0, 8'h00, 8'h01, "status_rst"};
      vecs[3]  = '{4'h3, 1'b0, 8'h00, 8'h00, "ctrl_rst"};
      vecs[4]  = '{4'h9, 1'b0, 8'h00, 8'h00, "unmapped_rd"};
      vecs[5]  = '{4'h1, 1'b1, 8'hA5, 8'hA5, "div_wr"};
      vecs[6]  = '{4'h3, 1'b1, 8'hFF, 8'h01, "ctrl_bit0"};
      vecs[7]  = '{4'h3, 1'b1, 8'hFE, 8'h00, "ctrl_clr"};
      vecs[8]  = '{4'h7, 1'b1, 8'hFF, 8'h00, "unmapped_wr"};
      vecs[9]  = '{4'h1, 1'b0, 8'h00, 8'hA5, "div_keep"};
      vecs[10] = '{4'h2, 1'b1, 8'hFF, 8'h01, "status_wr"};
      vecs[11] = '{4'hF, 1'b1, 8'h12, 8'h00, "unmapped_f"};
      vecs[12] = '{4'h1, 1'b1, 8'h03, 8'h03, "div_wr3"};

      // reset
      tick();
      tick();
      rst = 1'b0;
      check("uo_out_rst", uo_out, 8'h01);

      // register map table
      for (int v = 0; v < 13; v++) begin
         if (vecs[v].wr) write_reg(vecs[v].addr, vecs[v].wdata);
         read_check(vecs[v].name, vecs[v].addr, vecs[v].exp);
      end

      // DIV=3, single frame of 0x55, first pop one edge after the push
      write_reg(4'h3, 8'h01);
      write_reg(4'h0, 8'h55);
      expect_frame(7'h55, 4, 4, 1'b0, 8'h00);
      tick();
      check("after_55_uo", uo_out, 8'h01);
      read_check("after_55_status", 4'h2, 8'h01);

      // overflow: five pushes while disabled, then drain four in order
      write_reg(4'h3, 8'h00);
      write_reg(4'h1, 8'h00);
      for (int i = 1; i <= 5; i++) write_reg(4'h0, 8'(i));
      read_check("ovf_status", 4'h2, 8'h0A);
      read_check("ovf_count", 4'h0, 8'h04);
      write_reg(4'h3, 8'h01);
      for (int i = 1; i <= 4; i++) begin
         exp_cw = 7'(i);
         expect_frame(exp_cw, 1, 1, 1'b0, 8'h00);
         tick();
         check("ovf_gap_uo", uo_out, 8'h01);
      end
      repeat (5) tick();
      check("ovf_no5_uo", uo_out, 8'h01);
      read_check("ovf_drained_status", 4'h2, 8'h09);
      write_reg(4'h2, 8'h08);
      read_check("ovf_cleared", 4'h2, 8'h01);

      // push into a full FIFO on the pop cycle is accepted
      write_reg(4'h3, 8'h00);
      for (int i = 0; i < 4; i++) write_reg(4'h0, 8'h11 + 8'(i));
      write_reg(4'h3, 8'h01);
      write_reg(4'h0, 8'h15);
      read_check("fullpop_count", 4'h0, 8'h04);
      read_check("fullpop_status", 4'h2, 8'h06);
      for (int i = 0; i < 5; i++) begin
         rx_frame(got);
         check($sformatf("fullpop_rx%0d", i), {1'b0, got}, 8'h11 + 8'(i));
      end
      tick();
      tick();
      read_check("fullpop_end", 4'h2, 8'h01);

      // DIV=0 back-to-back 0x7F then 0x00, exactly one idle cycle between
      write_reg(4'h0, 8'h7F);
      address    = 4'h0;
      data_in    = 8'h00;
      data_write = 1'b1;
      expect_frame(7'h7F, 1, 1, 1'b0, 8'h00);
      tick();
      check("b2b_gap_uo", uo_out, 8'h01);
      expect_frame(7'h00, 1, 1, 1'b0, 8'h00);
      tick();
      check("b2b_end_uo", uo_out, 8'h01);
      read_check("b2b_end_status", 4'h2, 8'h01);

      // DIV 3 -> 1 during the start bit: start keeps 4 cycles, the rest take 2
      write_reg(4'h1, 8'h03);
      write_reg(4'h0, 8'h55);
      expect_frame(7'h55, 4, 2, 1'b1, 8'h01);
      tick();
      check("divchg_end_uo", uo_out, 8'h01);
      read_check("divchg_div", 4'h1, 8'h01);

      // clearing enable mid-frame with two entries queued
      write_reg(4'h0, 8'h2A);
      write_reg(4'h0, 8'h15);
      write_reg(4'h0, 8'h4C);
      write_reg(4'h3, 8'h00);
      check("endis_busy", {7'b0, uo_out[1]}, 8'h01);
      n = 0;
      while (uo_out[1] && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) bound_fail("endis_frame_end");
      read_check("endis_count", 4'h0, 8'h02);
      repeat (10) tick();
      check("endis_idle_uo", uo_out, 8'h01);
      read_check("endis_count_hold", 4'h0, 8'h02);
      write_reg(4'h3, 8'h01);
      address = 4'h0;
      n = 0;
      while ((data_out != 8'h00 || uo_out[1]) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) bound_fail("endis_drain");
      read_check("endis_drained", 4'h2, 8'h01);

      // reset in the middle of the data bits
      write_reg(4'h1, 8'h03);
      write_reg(4'h0, 8'h33);
      repeat (6) tick();
      check("midrst_pre_uo", uo_out, 8'h03);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_uo", uo_out, 8'h01);
      read_check("midrst_count", 4'h0, 8'h00);
      read_check("midrst_div", 4'h1, 8'h0F);
      read_check("midrst_ctrl", 4'h3, 8'h00);
      read_check("midrst_status", 4'h2, 8'h01);
      repeat (5) tick();
      check("midrst_quiet_uo", uo_out, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hamming_serial_tx.md
HAMMING_SERIAL_TX -- requirements
Module: hamming_serial_tx

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of 7-bit codeword entries in the transmit FIFO (power of two, 2..8).
REQ-002 Parameter: DIV_RESET, default 8'h0F, reset value of the bit-period divider register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 ui_in  input  8  unused; no effect on any state.
REQ-006 uo_out  output  8  bit0 = serial tx line; bit1 = busy; bits 7:2 = 0.
REQ-007 address  input  4  register select for reads and writes.
REQ-008 data_write  input  1  write strobe, one cycle per write.
REQ-009 data_in  input  8  write data; codeword from the Hamming encoder stage in bits 6:0.
REQ-010 data_out  output  8  combinational read data for the current address.

Function
REQ-011 Register map:
- 0x0 TXDATA: write pushes data_in[6:0]; read returns {5'b0, count[2:0]}.
- 0x1 DIV: r/w 8-bit; bit period = DIV+1 clk cycles.
- 0x2 STATUS: read {4'b0, overflow, busy, full, empty}; write with data_in[3]=1 clears overflow.
- 0x3 CTRL: r/w; bit0 = enable; other bits read 0.
- All other addresses: read 8'h00, writes ignored.
REQ-012 Push rule: accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the codeword is dropped, FIFO contents are unchanged, and overflow is set (sticky).
REQ-013 Overflow-set and an overflow-clear write in the same cycle: overflow ends set.
REQ-014 FIFO order is first-in first-out. Read/write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START in any cycle with enable=1 and count>0. That cycle pops the head entry into a 7-bit shift register, clears the bit index, and loads the baud counter with DIV.
REQ-017 Each of START, DATA-bit and STOP lasts exactly DIV+1 cycles. The baud counter decrements each cycle, and the bit period ends when it reaches 0.
REQ-018 tx line values:
- START: 0.
- DATA: shift register LSB; 7 bits sent bit0 first, shift right at each bit end.
- STOP: 1.
- IDLE and reset: 1.
- tx is registered (glitch-free).
REQ-019 DATA -> STOP after the 7th bit period. STOP -> IDLE at the end of the stop bit period. The next frame may start on the following cycle (one IDLE cycle minimum between frames).
REQ-020 busy = 1 in START, DATA and STOP; 0 in IDLE.
REQ-021 Latency: with FSM idle, enable=1 and FIFO empty, a push at edge k causes the pop at edge k+1, and tx reads 0 after edge k+1.
REQ-022 Clearing enable mid-frame: the current frame completes; no further pops occur.
REQ-023 Writing DIV mid-frame: the new value applies from the next baud counter reload; the current bit period is unaffected.
REQ-024 DIV=0: each bit lasts 1 cycle; a frame is 9 cycles.
REQ-025 Simultaneous push and pop with count=FIFO_DEPTH: the push is accepted and count is unchanged.

Reset
REQ-026 While rst=1 at a clock edge:
- FSM -> IDLE; FIFO emptied (pointers and count 0).
- overflow=0, enable=0, DIV=DIV_RESET.
- tx=1, busy=0, uo_out=8'h01.
REQ-027 Reset asserted mid-frame aborts the frame. The tx line is 1 after that edge, and the aborted codeword is not retransmitted.

Verification
REQ-028 DIV=3, enable=1, push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,1, each held 4 cycles (36 cycles total busy); then idle with tx=1 and empty=1.
REQ-029 enable=0, push 0x01,0x02,0x03,0x04,0x05 -> full=1, overflow=1, count=4. Set enable -> frames 0x01..0x04 sent in order and 0x05 never appears; write STATUS 0x08 -> overflow=0.
REQ-030 DIV=0, push 0x7F and 0x00 back-to-back -> two 9-cycle frames separated by exactly one IDLE cycle with tx=1; data bits all 1s, then all 0s.
REQ-031 Mid-DATA, assert rst for one cycle -> uo_out=8'h01 next cycle, count=0, DIV reads 0x0F, CTRL reads 0x00.
REQ-032 Mid-frame, clear enable with 2 entries queued -> the current frame finishes and busy drops; count stays 2 until enable=1.
REQ-033 Mid-frame, write DIV from 3 to 1 -> the current bit stays 4 cycles and subsequent bits are 2 cycles.
